// File: rtl/dtw_pkg.sv
// Shared types and helpers for the DTW distance crossbar: INF and zero-select codes and
// the derived select/tap field widths.
package dtw_pkg;

   localparam int unsigned MaxW = 64;

   function automatic int unsigned dtw_sel_w(input int unsigned n);
      return $clog2(n + 2);
   endfunction

   function automatic int unsigned dtw_tap_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // All-ones in the low w bits; callers take the slice they need.
   function automatic logic [MaxW-1:0] dtw_inf(input int unsigned w);
      logic [MaxW-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < MaxW; i++) begin
         if (i < w) v[i] = 1'b1;
      end
      return v;
   endfunction

   // The all-ones select code forces an operand to zero.
   function automatic logic [MaxW-1:0] dtw_sel_zero(input int unsigned sw);
      return dtw_inf(sw);
   endfunction

endpackage

// File: rtl/dtw_dc_xbar_if.sv
// Bundle of the crossbar's control, live vector, per-lane routing fields and routed outputs.
// The master drives the array side; the crossbar sits on the slave modport.
interface dtw_dc_xbar_if
   import dtw_pkg::*;
#(
   parameter int unsigned N     = 6,
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned SW    = dtw_sel_w(N),
   parameter int unsigned TW    = dtw_tap_w(DEPTH)
) ();

   logic            ena;
   logic            clr;
   logic            i_vld;
   logic [N*W-1:0]  i_d;
   logic [N*SW-1:0] i_sel0;
   logic [N*SW-1:0] i_sel1;
   logic [N*SW-1:0] i_sel2;
   logic [N*TW-1:0] i_tap0;
   logic [N*TW-1:0] i_tap1;
   logic [N*TW-1:0] i_tap2;
   logic [N*W-1:0]  o_d0;
   logic [N*W-1:0]  o_d1;
   logic [N*W-1:0]  o_d2;
   logic            o_vld;
   logic [TW-1:0]   o_fill;

   modport master (
      output ena, clr, i_vld, i_d, i_sel0, i_sel1, i_sel2, i_tap0, i_tap1, i_tap2,
      input  o_d0, o_d1, o_d2, o_vld, o_fill
   );

   modport slave (
      input  ena, clr, i_vld, i_d, i_sel0, i_sel1, i_sel2, i_tap0, i_tap1, i_tap2,
      output o_d0, o_d1, o_d2, o_vld, o_fill
   );

endinterface

// File: rtl/dtw_dc_hist.sv
// Ring history of accepted distance vectors with write pointer and saturating fill count.
// Each read port maps a tap (k-th previous accept) to {hit, vector}; tap 0 is never a hit.
module dtw_dc_hist
   import dtw_pkg::*;
#(
   parameter int unsigned N     = 6,
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned TW    = dtw_tap_w(DEPTH),
   parameter int unsigned NRd   = 3 * N
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     ena_i,
   input  logic                     clr_i,
   input  logic                     vld_i,
   input  logic [N*W-1:0]           wdata_i,
   input  logic [NRd-1:0][TW-1:0]   rd_tap_i,
   output logic [NRd-1:0]           rd_hit_o,
   output logic [NRd-1:0][N*W-1:0]  rd_vec_o,
   output logic [TW-1:0]            fill_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0][N*W-1:0] mem_q, mem_d;
   logic [PW-1:0]             ptr_q, ptr_d;
   logic [TW-1:0]             fill_q, fill_d;

   // Clear is applied before the push so a same-cycle push lands in slot 0.
   always_comb begin
      mem_d  = mem_q;
      ptr_d  = ptr_q;
      fill_d = fill_q;
      if (clr_i) begin
         ptr_d  = '0;
         fill_d = '0;
      end
      if (ena_i && vld_i) begin
         mem_d[ptr_d] = wdata_i;
         ptr_d        = (32'(ptr_d) == DEPTH - 1) ? '0 : ptr_d + PW'(1);
         if (32'(fill_d) < DEPTH) fill_d = fill_d + TW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q  <= '0;
         ptr_q  <= '0;
         fill_q <= '0;
      end else begin
         mem_q  <= mem_d;
         ptr_q  <= ptr_d;
         fill_q <= fill_d;
      end
   end

   // fill never exceeds DEPTH, so tap <= fill also bounds the tap to stored entries.
   always_comb begin
      int unsigned idx;
      idx      = 0;
      rd_hit_o = '0;
      rd_vec_o = '0;
      for (int unsigned p = 0; p < NRd; p++) begin
         rd_hit_o[p] = (rd_tap_i[p] != '0) && (rd_tap_i[p] <= fill_q);
         if (rd_hit_o[p]) begin
            idx         = (32'(ptr_q) + DEPTH - 32'(rd_tap_i[p])) % DEPTH;
            rd_vec_o[p] = mem_q[PW'(idx)];
         end
      end
   end

   assign fill_o = fill_q;

endmodule

// File: rtl/dtw_dc_xbar.sv
// Distance crossbar for the DTW systolic array: per lane, routes D0/D1/D2 from any lane at any
// history tap (or forces 0/INF) into a registered output stage with a valid flag.
module dtw_dc_xbar
   import dtw_pkg::*;
#(
   parameter int unsigned N     = 6,
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned SW    = dtw_sel_w(N),
   parameter int unsigned TW    = dtw_tap_w(DEPTH)
) (
   input  logic          clk,
   input  logic          nrst,
   dtw_dc_xbar_if.slave  bus
);

   localparam int unsigned    NRd         = 3 * N;
   localparam logic [MaxW-1:0] InfFull     = dtw_inf(W);
   localparam logic [MaxW-1:0] SelZeroFull = dtw_sel_zero(SW);
   localparam logic [W-1:0]    Inf         = InfFull[W-1:0];
   localparam logic [SW-1:0]   SelZero     = SelZeroFull[SW-1:0];

   logic [SW-1:0]            sel [3][N];
   logic [TW-1:0]            tap [3][N];
   logic [NRd-1:0][TW-1:0]   rd_tap;
   logic [NRd-1:0]           rd_hit;
   logic [NRd-1:0][N*W-1:0]  rd_vec;
   logic [TW-1:0]            fill;
   logic [2:0][N*W-1:0]      dec;
   logic [2:0][N*W-1:0]      d_q, d_d;
   logic                     vld_q, vld_d;

   // Unpack the per-lane fields; lane 0 sits in the MSBs of every bus.
   always_comb begin
      sel    = '{default: '0};
      tap    = '{default: '0};
      rd_tap = '0;
      for (int unsigned l = 0; l < N; l++) begin
         sel[0][l] = bus.i_sel0[(N-1-l)*SW +: SW];
         sel[1][l] = bus.i_sel1[(N-1-l)*SW +: SW];
         sel[2][l] = bus.i_sel2[(N-1-l)*SW +: SW];
         tap[0][l] = bus.i_tap0[(N-1-l)*TW +: TW];
         tap[1][l] = bus.i_tap1[(N-1-l)*TW +: TW];
         tap[2][l] = bus.i_tap2[(N-1-l)*TW +: TW];
      end
      for (int unsigned op = 0; op < 3; op++) begin
         for (int unsigned l = 0; l < N; l++) begin
            rd_tap[op*N+l] = tap[op][l];
         end
      end
   end

   dtw_dc_hist #(
      .N     (N),
      .W     (W),
      .DEPTH (DEPTH),
      .TW    (TW),
      .NRd   (NRd)
   ) u_hist (
      .clk_i    (clk),
      .rst_ni   (nrst),
      .ena_i    (bus.ena),
      .clr_i    (bus.clr),
      .vld_i    (bus.i_vld),
      .wdata_i  (bus.i_d),
      .rd_tap_i (rd_tap),
      .rd_hit_o (rd_hit),
      .rd_vec_o (rd_vec),
      .fill_o   (fill)
   );

   // Zero code wins over everything, then invalid lanes, then tap resolution.
   always_comb begin
      int unsigned s;
      logic [W-1:0] val;
      s   = 0;
      val = '0;
      dec = '0;
      for (int unsigned op = 0; op < 3; op++) begin
         for (int unsigned l = 0; l < N; l++) begin
            s = 32'(sel[op][l]);
            if (sel[op][l] == SelZero) begin
               val = '0;
            end else if (s >= N) begin
               val = Inf;
            end else if (tap[op][l] == '0) begin
               val = bus.i_d[(N-1-s)*W +: W];
            end else if (rd_hit[op*N+l]) begin
               val = rd_vec[op*N+l][(N-1-s)*W +: W];
            end else begin
               val = Inf;
            end
            dec[op][(N-1-l)*W +: W] = val;
         end
      end
   end

   always_comb begin
      d_d   = d_q;
      vld_d = 1'b0;
      if (bus.ena) begin
         d_d   = dec;
         vld_d = bus.i_vld;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         d_q   <= '0;
         vld_q <= 1'b0;
      end else begin
         d_q   <= d_d;
         vld_q <= vld_d;
      end
   end

   assign bus.o_d0   = d_q[0];
   assign bus.o_d1   = d_q[1];
   assign bus.o_d2   = d_q[2];
   assign bus.o_vld  = vld_q;
   assign bus.o_fill = fill;

endmodule

// File: tb/tb_dtw_dc_xbar.sv
// Randomized bench for dtw_dc_xbar: a queue-based history model predicts every output cycle,
// plus directed scenarios for taps, select codes, stall, clear, wrap and async reset.
module tb_dtw_dc_xbar;
   import dtw_pkg::*;

   localparam int unsigned N     = 6;
   localparam int unsigned W     = 16;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned SW    = 3;
   localparam int unsigned TW    = 2;
   localparam int unsigned SelZ  = 7;
   localparam logic [W-1:0] Inf  = 16'hffff;

   logic clk;
   logic nrst;

   dtw_dc_xbar_if #(.N(N), .W(W), .DEPTH(DEPTH)) bus ();

   dtw_dc_xbar #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk;
   int n_pass;

   // Model state: newest accepted vector at the front of the queue.
   logic [N*W-1:0] hq[$];
   logic [N*W-1:0] exp_d[3];
   logic           exp_vld;
   int             sel[3][N];
   int             tap[3][N];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [W-1:0] lane_of(input logic [N*W-1:0] v, input int l);
      return v[(N-1-l)*W +: W];
   endfunction

   function automatic logic [W-1:0] ref_val(input int s, input int t, input logic [N*W-1:0] live);
      if (s == SelZ) return '0;
      if (s >= N) return Inf;
      if (t == 0) return lane_of(live, s);
      if (t <= hq.size()) return lane_of(hq[t-1], s);
      return Inf;
   endfunction

   function automatic logic [N*W-1:0] rand_vec();
      logic [N*W-1:0] v;
      for (int l = 0; l < N; l++) v[(N-1-l)*W +: W] = W'($urandom);
      return v;
   endfunction

   task automatic drive(input logic e, input logic c, input logic v, input logic [N*W-1:0] d);
      bus.ena   = e;
      bus.clr   = c;
      bus.i_vld = v;
      bus.i_d   = d;
      for (int l = 0; l < N; l++) begin
         bus.i_sel0[(N-1-l)*SW +: SW] = SW'(sel[0][l]);
         bus.i_sel1[(N-1-l)*SW +: SW] = SW'(sel[1][l]);
         bus.i_sel2[(N-1-l)*SW +: SW] = SW'(sel[2][l]);
         bus.i_tap0[(N-1-l)*TW +: TW] = TW'(tap[0][l]);
         bus.i_tap1[(N-1-l)*TW +: TW] = TW'(tap[1][l]);
         bus.i_tap2[(N-1-l)*TW +: TW] = TW'(tap[2][l]);
      end
   endtask

   task automatic set_route(input int op, input int s, input int t);
      for (int l = 0; l < N; l++) begin
         sel[op][l] = s;
         tap[op][l] = t;
      end
   endtask

   task automatic randomize_route();
      for (int op = 0; op < 3; op++) begin
         for (int l = 0; l < N; l++) begin
            sel[op][l] = int'($urandom_range(0, 7));
            tap[op][l] = int'($urandom_range(0, 3));
         end
      end
   endtask

   // Predict from the inputs now applied, clock once, compare all outputs.
   task automatic step(input string tag);
      logic [N*W-1:0] nd[3];
      if (bus.ena) begin
         for (int op = 0; op < 3; op++) begin
            for (int l = 0; l < N; l++) nd[op][(N-1-l)*W +: W] = ref_val(sel[op][l], tap[op][l], bus.i_d);
         end
         exp_d   = nd;
         exp_vld = bus.i_vld;
      end else begin
         exp_vld = 1'b0;
      end
      if (bus.clr) hq.delete();
      if (bus.ena && bus.i_vld) begin
         hq.push_front(bus.i_d);
         if (hq.size() > DEPTH) void'(hq.pop_back());
      end
      @(posedge clk);
      #1;
      check({tag, ".d0"}, bus.o_d0, exp_d[0]);
      check({tag, ".d1"}, bus.o_d1, exp_d[1]);
      check({tag, ".d2"}, bus.o_d2, exp_d[2]);
      check({tag, ".vld"}, bus.o_vld, exp_vld);
      check({tag, ".fill"}, bus.o_fill, hq.size());
   endtask

   task automatic model_reset();
      hq.delete();
      for (int op = 0; op < 3; op++) exp_d[op] = '0;
      exp_vld = 1'b0;
   endtask

   initial begin
      logic [N*W-1:0] v;
      int             f0;
      logic [N*W-1:0] held;
      n_chk = 0;
      n_pass = 0;
      nrst = 1'b0;
      for (int op = 0; op < 3; op++) set_route(op, 0, 0);
      drive(1'b0, 1'b0, 1'b0, '0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst.d0", bus.o_d0, 96'd0);
      check("rst.vld", bus.o_vld, 1'b0);
      check("rst.fill", bus.o_fill, 2'd0);
      @(negedge clk);
      nrst = 1'b1;

      // Three pushes, lane0 = 10, 20, 30; third read on taps 0/1/2.
      set_route(0, 0, 0);
      set_route(1, 0, 1);
      set_route(2, 0, 2);
      for (int k = 1; k <= 3; k++) begin
         v = rand_vec();
         v[N*W-1 -: W] = W'(10 * k);
         drive(1'b1, 1'b0, 1'b1, v);
         step("push");
      end
      check("tap0.lane0", lane_of(bus.o_d0, 0), 16'd30);
      check("tap1.lane0", lane_of(bus.o_d1, 0), 16'd20);
      check("tap2.lane0", lane_of(bus.o_d2, 0), 16'd10);

      // Select codes: zero, out-of-range, live lane 5.
      set_route(0, 7, 2);
      set_route(1, 6, 0);
      set_route(2, 5, 0);
      v = rand_vec();
      drive(1'b1, 1'b0, 1'b1, v);
      step("sel");
      check("sel7.zero", bus.o_d0, 96'd0);
      check("sel6.inf", lane_of(bus.o_d1, 3), Inf);
      check("sel5.live", lane_of(bus.o_d2, 0), lane_of(v, 5));
      check("sel5.vld", bus.o_vld, 1'b1);

      // Stall with valid input: outputs, fill and history hold.
      f0 = hq.size();
      held = exp_d[0];
      randomize_route();
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 1'b1, rand_vec());
         step("stall");
      end
      check("stall.fill", bus.o_fill, f0);
      check("stall.d0", bus.o_d0, held);

      // Clear with push of 55, then read taps 1/2, then clear alone.
      v = rand_vec();
      v[N*W-1 -: W] = 16'd55;
      drive(1'b1, 1'b1, 1'b1, v);
      step("clrpush");
      check("clrpush.fill", bus.o_fill, 2'd1);
      set_route(0, 0, 1);
      set_route(1, 0, 2);
      set_route(2, 1, 1);
      drive(1'b1, 1'b0, 1'b0, rand_vec());
      step("clrread");
      check("clr.tap1", lane_of(bus.o_d0, 0), 16'd55);
      check("clr.tap2", lane_of(bus.o_d1, 0), Inf);
      drive(1'b1, 1'b1, 1'b0, rand_vec());
      step("clronly");
      check("clronly.fill", bus.o_fill, 2'd0);

      // Wrap: five pushes, fill saturates.
      for (int k = 0; k < 5; k++) begin
         randomize_route();
         drive(1'b1, 1'b0, 1'b1, rand_vec());
         step("wrap");
      end
      check("wrap.fill", bus.o_fill, 2'd2);

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         randomize_route();
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
               $urandom_range(0, 9) < 7, rand_vec());
         step("rand");
      end

      // Async reset mid-traffic.
      randomize_route();
      drive(1'b1, 1'b0, 1'b1, rand_vec());
      @(negedge clk);
      #2;
      nrst = 1'b0;
      #1;
      model_reset();
      check("midrst.d0", bus.o_d0, 96'd0);
      check("midrst.d2", bus.o_d2, 96'd0);
      check("midrst.vld", bus.o_vld, 1'b0);
      check("midrst.fill", bus.o_fill, 2'd0);
      @(negedge clk);
      nrst = 1'b1;
      set_route(0, 0, 1);
      set_route(1, 2, 1);
      set_route(2, 0, 0);
      drive(1'b1, 1'b0, 1'b1, rand_vec());
      step("postrst");
      check("postrst.tap1", lane_of(bus.o_d0, 0), Inf);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
